// File: rtl/fetch_ctrl_if.sv
// Instruction fetch interface.
// Groups the instruction-memory request/response channel, the redirect input
// and the decoded-instruction output handshake used by fetch_ctrl.
//   master : fetch_ctrl side (drives imem request and instruction output)
//   slave  : environment side (memory, branch unit, decode)
// Signal names keep their direction suffixes relative to fetch_ctrl.
interface fetch_ctrl_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    modport master (
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i,
               instr_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i,
               instr_ready_i
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller.
// Issues one outstanding instruction-memory request at a time, buffers the
// returned word in a one-entry output buffer and handles branch redirects,
// discarding a response that belongs to a fetch made before the redirect.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high reset
//   bus   : fetch_ctrl_if.master (imem request/response, redirect, instr out)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | one cycle after reset, no request
// REQ   | request may be raised when the output buffer has room
// WAIT  | request granted, waiting for imem_rvalid_i
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] inflight_pc;
    logic        drop;
    logic        buf_valid;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;
    logic        req;
    logic        fire;
    logic        xfer;
    logic        resp;
    logic        fill;

    assign xfer = buf_valid & bus.instr_ready_i;
    assign fire = req & bus.imem_gnt_i;
    // rvalid is only meaningful while a request is outstanding
    assign resp = (state == WAIT) & bus.imem_rvalid_i;
    assign fill = resp & ~drop & ~bus.redirect_i;

    always_comb begin
        state_next = state;
        req        = 1'b0;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                // room exists if the buffer is empty or drains this cycle
                req = (~buf_valid | xfer) & ~bus.redirect_i;
                if (bus.redirect_i) begin
                    state_next = REQ;
                end else if (req && bus.imem_gnt_i) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid_i) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inflight_pc <= 32'h0;
            drop        <= 1'b0;
            buf_valid   <= 1'b0;
            buf_instr   <= 32'h0;
            buf_pc      <= 32'h0;
        end else begin
            state <= state_next;

            if (bus.redirect_i) begin
                pc <= bus.redirect_pc_i;
            end else if (fire) begin
                pc <= pc + 32'd4;
            end

            if (fire) begin
                inflight_pc <= pc;
            end

            // a redirect while waiting marks the in-flight response stale;
            // any response seen in WAIT retires the single outstanding fetch
            if (resp) begin
                drop <= 1'b0;
            end else if ((state == WAIT) && bus.redirect_i) begin
                drop <= 1'b1;
            end

            if (fill) begin
                buf_valid <= 1'b1;
                buf_instr <= bus.imem_rdata_i;
                buf_pc    <= inflight_pc;
            end else if (xfer || bus.redirect_i) begin
                buf_valid <= 1'b0;
            end
        end
    end

    assign bus.imem_req_o    = req;
    assign bus.imem_addr_o   = pc;
    assign bus.instr_valid_o = buf_valid;
    assign bus.instr_o       = buf_instr;
    assign bus.instr_pc_o    = buf_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl.
// Directed segments, each started from reset. Expected request addresses and
// expected (pc, instruction) transfers are queued up front; a monitor process
// compares every granted request and every output transfer against the queues.
// Instruction memory returns addr ^ key, latency chosen per request.
module tb_fetch_ctrl;

    logic clk;
    logic reset;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_ipc_q[$];
    logic [31:0] exp_instr_q[$];
    int          xfer_q[$];

    // memory model
    bit          mem_pend = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_data = 32'h0;
    int          lat      = 1;
    logic [31:0] key      = 32'hDEAD_0000;

    // values sampled mid-cycle by the driver
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_instr;
    logic [31:0] s_ipc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic push_instr(input logic [31:0] pc, input logic [31:0] data);
        exp_ipc_q.push_back(pc);
        exp_instr_q.push_back(data);
    endtask

    // one clock cycle: inputs already set by caller at the falling edge
    task automatic cyc();
        bus.imem_rvalid_i = mem_pend && (mem_cnt == 0);
        bus.imem_rdata_i  = mem_data;
        #3;
        s_req   = bus.imem_req_o;
        s_addr  = bus.imem_addr_o;
        s_valid = bus.instr_valid_o;
        s_instr = bus.instr_o;
        s_ipc   = bus.instr_pc_o;
        if (bus.imem_rvalid_i) mem_pend = 1'b0;
        else if (mem_pend) mem_cnt--;
        if (bus.imem_req_o && bus.imem_gnt_i && !reset) begin
            mem_pend = 1'b1;
            mem_cnt  = lat - 1;
            mem_data = bus.imem_addr_o ^ key;
        end
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic do_reset(input bit clear_mem);
        if (clear_mem) mem_pend = 1'b0;
        xfer_q.delete();
        reset = 1'b1;
        cyc();
        chk("req_in_reset", {31'b0, s_req}, 32'h0);
        bus.redirect_i = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
        chk("idle_req", {31'b0, s_req}, 32'h0);
        chk("rst_valid", {31'b0, s_valid}, 32'h0);
        chk("rst_instr", s_instr, 32'h0);
        chk("rst_instr_pc", s_ipc, 32'h0);
        chk("rst_pc", s_addr, 32'h0000_0000);
    endtask

    task automatic seg_end(input string name);
        chk({name, "_addr_left"}, exp_addr_q.size(), 32'h0);
        chk({name, "_instr_left"}, exp_ipc_q.size(), 32'h0);
        exp_addr_q.delete();
        exp_ipc_q.delete();
        exp_instr_q.delete();
    endtask

    // scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!reset) begin
                if (bus.imem_req_o && bus.imem_gnt_i) begin
                    if (exp_addr_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL req_addr: got %h expected no request (cycle %0d)",
                                 bus.imem_addr_o, cyc_n);
                    end else begin
                        chk("req_addr", bus.imem_addr_o, exp_addr_q.pop_front());
                    end
                end
                if (bus.instr_valid_o && bus.instr_ready_i) begin
                    xfer_q.push_back(cyc_n);
                    if (exp_ipc_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL xfer: got pc %h instr %h expected no transfer (cycle %0d)",
                                 bus.instr_pc_o, bus.instr_o, cyc_n);
                    end else begin
                        chk("xfer_pc", bus.instr_pc_o, exp_ipc_q.pop_front());
                        chk("xfer_instr", bus.instr_o, exp_instr_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset             = 1'b1;
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.instr_ready_i = 1'b0;
        @(negedge clk);

        // A: streaming, then back-pressure on a full buffer
        exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        push_instr(32'h0, 32'hDEAD_0000);
        push_instr(32'h4, 32'hDEAD_0004);
        push_instr(32'h8, 32'hDEAD_0008);
        push_instr(32'hC, 32'hDEAD_000C);
        do_reset(1'b1);
        bus.imem_gnt_i = 1'b1; bus.instr_ready_i = 1'b1; lat = 1; key = 32'hDEAD_0000;
        for (int i = 1; i <= 8; i++) cyc();
        bus.instr_ready_i = 1'b0;
        cyc();
        chk("full_no_req_a", {31'b0, s_req}, 32'h0);
        cyc();
        chk("full_no_req_b", {31'b0, s_req}, 32'h0);
        chk("full_valid", {31'b0, s_valid}, 32'h1);
        bus.instr_ready_i = 1'b1;
        cyc();
        chk("req_with_xfer", {31'b0, s_req}, 32'h1);
        bus.instr_ready_i = 1'b0;
        cyc();
        cyc();
        chk("full_no_req_c", {31'b0, s_req}, 32'h0);
        chk("xfer_count", xfer_q.size(), 32'd4);
        if (xfer_q.size() == 4) begin
            chk("gap_01", xfer_q[1] - xfer_q[0], 32'd2);
            chk("gap_12", xfer_q[2] - xfer_q[1], 32'd2);
            chk("gap_03", xfer_q[3] - xfer_q[0], 32'd8);
        end
        seg_end("seg_a");

        // B: two redirects during WAIT for addr 8, late response dropped
        exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104};
        push_instr(32'h0, 32'hDEAD_0000);
        push_instr(32'h4, 32'hDEAD_0004);
        push_instr(32'h100, 32'hDEAD_0100);
        do_reset(1'b1);
        bus.instr_ready_i = 1'b1; lat = 1;
        for (int i = 1; i <= 4; i++) cyc();
        lat = 4;
        cyc();
        lat = 1;
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h80;
        cyc();
        chk("wait_no_req", {31'b0, s_req}, 32'h0);
        bus.redirect_pc_i = 32'h100;
        cyc();
        chk("redir_valid_b", {31'b0, s_valid}, 32'h0);
        bus.redirect_i = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("drop_not_buffered", {31'b0, s_valid}, 32'h0);
        chk("redir_addr_b", s_addr, 32'h100);
        cyc();
        cyc();
        bus.instr_ready_i = 1'b0;
        cyc();
        cyc();
        chk("b_full_no_req", {31'b0, s_req}, 32'h0);
        seg_end("seg_b");

        // C: redirect with same-cycle rvalid, then redirect in REQ with transfer
        exp_addr_q = '{32'h0, 32'h40, 32'h44, 32'h200, 32'h204};
        push_instr(32'h40, 32'hDEAD_0040);
        push_instr(32'h44, 32'hDEAD_0044);
        push_instr(32'h200, 32'hDEAD_0200);
        do_reset(1'b1);
        bus.instr_ready_i = 1'b1; lat = 1;
        cyc();
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h40;
        cyc();
        bus.redirect_i = 1'b0;
        cyc();
        chk("rv_redir_valid", {31'b0, s_valid}, 32'h0);
        chk("rv_redir_addr", s_addr, 32'h40);
        chk("rv_redir_req", {31'b0, s_req}, 32'h1);
        cyc();
        cyc();
        bus.instr_ready_i = 1'b0;
        cyc();
        cyc();
        bus.instr_ready_i = 1'b1;
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h200;
        cyc();
        chk("req_redir_forced0", {31'b0, s_req}, 32'h0);
        bus.redirect_i = 1'b0;
        cyc();
        chk("req_redir_valid", {31'b0, s_valid}, 32'h0);
        chk("req_redir_addr", s_addr, 32'h200);
        cyc();
        cyc();
        bus.instr_ready_i = 1'b0;
        cyc();
        cyc();
        seg_end("seg_c");

        // D: pc wrap at the top of the address space
        exp_addr_q = '{32'hFFFF_FFFC, 32'h0, 32'h4};
        push_instr(32'hFFFF_FFFC, 32'h2152_FFFC);
        push_instr(32'h0, 32'hDEAD_0000);
        do_reset(1'b1);
        bus.instr_ready_i = 1'b1; lat = 1;
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'hFFFF_FFFC;
        cyc();
        chk("redir_req_forced0", {31'b0, s_req}, 32'h0);
        bus.redirect_i = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("wrap_addr", s_addr, 32'h0);
        chk("wrap_instr_pc", s_ipc, 32'hFFFF_FFFC);
        cyc();
        cyc();
        bus.instr_ready_i = 1'b0;
        cyc();
        cyc();
        seg_end("seg_d");

        // E: reset abandons a fetch in WAIT; its late rvalid is ignored
        exp_addr_q = '{32'h0, 32'h0, 32'h4};
        push_instr(32'h0, 32'hDEAD_0000);
        do_reset(1'b1);
        bus.instr_ready_i = 1'b1; lat = 6; key = 32'h5A5A_0000;
        cyc();
        bus.imem_gnt_i = 1'b0; lat = 1; key = 32'hDEAD_0000;
        reset = 1'b1; bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h300;
        cyc();
        chk("req_in_reset_redir", {31'b0, s_req}, 32'h0);
        bus.redirect_i = 1'b0;
        do_reset(1'b0);
        cyc();
        cyc();
        chk("stale_rvalid_seen", {31'b0, bus.imem_rvalid_i}, 32'h1);
        chk("req_held_no_gnt", {31'b0, s_req}, 32'h1);
        bus.imem_gnt_i = 1'b1;
        cyc();
        chk("stale_ignored", {31'b0, s_valid}, 32'h0);
        chk("post_rst_addr", s_addr, 32'h0);
        cyc();
        cyc();
        bus.instr_ready_i = 1'b0;
        cyc();
        cyc();
        seg_end("seg_e");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
